// File: rtl/uart_rx_ascii.sv
// UART 8N1 receiver feeding the verify sequence checker.
// Centre-samples each bit; flags bad stop bits and rejects start glitches.
module uart_rx_ascii #(
  parameter int UART_RX_BAUD = 20,
  parameter int freq         = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = freq / UART_RX_BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_ratio
    $error("uart_rx_ascii: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, rx_s_q;

  // Sync flops reset high so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rx_s_q <= meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    char_d  = char_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          // LSB arrives first, so shifting right restores bit order.
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            char_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ascii_char    = char_q;
  assign char_valid    = valid_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_ascii.md
Name: uart_rx_ascii

Overview:
- UART 8N1 receiver that sits directly upstream of the `verify` sequence-checker.
- Converts the serial `rx` line into the `ascii_char`/`char_valid` byte stream that `verify` consumes.
- Samples each bit once, at its centre, using a clock-cycle counter derived from `freq` and `UART_RX_BAUD`.
- Flags stop-bit errors and rejects glitches on the start bit.

Parameters:
- `UART_RX_BAUD`, 20, serial bit rate in bits per time unit.
- `freq`, 200, clk frequency in the same unit.
- `CLKS_PER_BIT`, `freq/UART_RX_BAUD` (localparam), clocks per bit. Must be >= 4; elaboration fails otherwise.
- `HALF_BIT`, `CLKS_PER_BIT/2` (localparam), clocks from the detected start edge to the start-bit centre.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line; idle high; LSB first; 1 start bit, 8 data bits, 1 stop bit, no parity.
- `ascii_char` output 8: last correctly received byte; held until the next valid byte.
- `char_valid` output 1: one-cycle pulse; `ascii_char` is valid in that cycle.
- `framing_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `rx_busy` output 1: high in every state except IDLE.

Behaviour:
- Reset values:
  - `ascii_char` = 0x00; `char_valid`, `framing_error` = 0; `rx_busy` = 0.
  - State = IDLE; counter = 0; bit index = 0; shift register = 0.
  - Both synchronizer flops = 1, so no false start is seen coming out of reset.
- Input sync: `rx` passes through 2 flops to give `rx_s`; all decisions use `rx_s`.
- IDLE:
  - `rx_s`==0 -> go to START, counter = 0.
  - Otherwise stay in IDLE.
- START:
  - Counter increments each clock.
  - At counter==`HALF_BIT`-1, sample `rx_s`:
    - 0 -> go to DATA, counter = 0, bit index = 0.
    - 1 -> glitch; return to IDLE with no outputs.
- DATA:
  - At counter==`CLKS_PER_BIT`-1: shift `rx_s` into the MSB of the shift register (right shift, so LSB-first order is restored), counter = 0, bit index +1.
  - After the 8th sample -> go to STOP.
- STOP, at counter==`CLKS_PER_BIT`-1:
  - `rx_s`==1 -> `ascii_char` <= shift register and `char_valid` <= 1 on the same edge; go to IDLE.
  - `rx_s`==0 -> `framing_error` <= 1; `ascii_char` unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 bytes.
- Pulse width: `char_valid` and `framing_error` are registered and cleared on the next clock; each is exactly 1 cycle. They are never high together.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit centre, so a start edge that follows immediately is caught.
  - Frames at the nominal rate must not be dropped.
- Latency: `char_valid` rises 2 + `HALF_BIT` + 9·`CLKS_PER_BIT` clocks (±1) after `rx` falls for the start bit.
  - With default parameters this is 97 ±1 clocks.
- Reset mid-frame: returns to IDLE immediately and discards the partial byte. No pulse is generated during or after reset.
- 0x00 data is legal: it produces `char_valid` with `ascii_char` = 0x00. `verify` uses 0x00 as a delimiter.
- Counter width: $clog2(`CLKS_PER_BIT`); the counter never wraps except on the explicit resets to 0 above.

Test Plan:
- Default parameters (10 clk/bit); send the frame for 0x31 ('1') after reset:
  - exactly one `char_valid` pulse, with `ascii_char`==0x31;
  - `framing_error` stays 0;
  - `rx_busy` is high for about 97 clocks.
- Send "123+456" as back-to-back frames with 0 idle bits between them:
  - 7 `char_valid` pulses with 0x31, 0x32, 0x33, 0x2B, 0x34, 0x35, 0x36 in order, at 100-clock spacing;
  - no errors.
- Drive `rx` low for 3 clocks, then high:
  - no `char_valid`, no `framing_error`;
  - `rx_busy` returns to 0 within `HALF_BIT`+3 clocks.
- Send 0x55 with the stop bit forced to 0, then hold `rx` low for 30 clocks, then high, then send 0x41:
  - one `framing_error` pulse;
  - `ascii_char` stays at its previous value;
  - afterwards exactly one `char_valid` with 0x41.
- Assert `rst` for 5 clocks in the middle of the data bits of 0x7E, then send 0x0A:
  - no pulse for 0x7E;
  - `ascii_char` = 0x00 after reset;
  - then `char_valid` with 0x0A.
- Send 0x00, then 0xFF:
  - `char_valid` with 0x00, then `char_valid` with 0xFF;
  - no `framing_error`.
